// File: rtl/vram_write_fifo.sv
// -----------------------------------------------------------------------------
// vram_write_fifo
//   Synchronous FIFO that holds Hack CPU video-RAM writes ({address, data})
//   until the SPI SRAM write state machine pops them one at a time and
//   serialises them to the external 23LC1024.
//
// Parameters
//   DATA_WIDTH     width of a queued data word
//   ADDRESS_WIDTH  width of a queued Hack RAM address
//   DEPTH_LOG2     log2 of the number of entries
//
// Ports
//   clk            single clock, all logic on posedge
//   reset          synchronous, active-high
//   write_request  push {write_address, write_data} this cycle
//   write_address  address to queue
//   write_data     data to queue
//   read_request   pop the head entry this cycle
//   read_address   registered address of the last popped entry
//   read_data      registered data of the last popped entry
//   items_count    number of stored entries, 0..2**DEPTH_LOG2
//   full / empty   items_count at its maximum / zero
//   overrun        push attempted while full (and not freed by a same-cycle pop)
//   underrun       pop attempted while empty
//
// Configuration macro
//   VRAM_FIFO_STICKY_ERR_EN : when defined, overrun/underrun stay set until
//                             reset; otherwise they are one-cycle pulses.
// -----------------------------------------------------------------------------
module vram_write_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 14,
    parameter int DEPTH_LOG2    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_request,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     read_request,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic [DEPTH_LOG2:0]      items_count,
    output logic                     full,
    output logic                     empty,
    output logic                     overrun,
    output logic                     underrun
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH;

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    // Storage without reset so it maps onto block RAM.
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]      count_q, count_d;
    logic                     full_q, full_d;
    logic                     empty_q, empty_d;
    logic                     overrun_q, overrun_d;
    logic                     underrun_q, underrun_d;
    logic [ADDRESS_WIDTH-1:0] raddr_q;
    logic [DATA_WIDTH-1:0]    rdata_q;

    logic pop_ok;
    logic push_ok;
    logic overrun_evt;
    logic underrun_evt;

    always_comb begin
        pop_ok       = read_request && !empty_q;
        // When full, a same-cycle pop frees the slot the push lands in.
        push_ok      = write_request && (!full_q || pop_ok);
        overrun_evt  = write_request && !push_ok;
        underrun_evt = read_request && empty_q;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
        full_d  = (count_d == FULL_COUNT);
        empty_d = (count_d == '0);

`ifdef VRAM_FIFO_STICKY_ERR_EN
        overrun_d  = overrun_q  || overrun_evt;
        underrun_d = underrun_q || underrun_evt;
`else
        overrun_d  = overrun_evt;
        underrun_d = underrun_evt;
`endif
    end

    // When full and pushing+popping, wr_ptr == rd_ptr: the read below sees
    // the old entry because both are non-blocking on the same edge.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem_q[wr_ptr_q] <= {write_address, write_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            raddr_q    <= '0;
            rdata_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
            // read_* only ever change on a successful pop.
            if (pop_ok) begin
                {raddr_q, rdata_q} <= mem_q[rd_ptr_q];
            end
        end
    end

    assign read_address = raddr_q;
    assign read_data    = rdata_q;
    assign items_count  = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign overrun      = overrun_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_vram_write_fifo.sv
module tb_vram_write_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_request = 1'b0;
    logic [13:0] write_address = '0;
    logic [15:0] write_data = '0;
    logic        read_request = 1'b0;
    logic [13:0] read_address;
    logic [15:0] read_data;
    logic [4:0]  items_count;
    logic        full;
    logic        empty;
    logic        overrun;
    logic        underrun;

    always #5 clk = ~clk;

    vram_write_fifo #(
        .DATA_WIDTH   (16),
        .ADDRESS_WIDTH(14),
        .DEPTH_LOG2   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_request(write_request),
        .write_address(write_address),
        .write_data   (write_data),
        .read_request (read_request),
        .read_address (read_address),
        .read_data    (read_data),
        .items_count  (items_count),
        .full         (full),
        .empty        (empty),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    typedef struct {
        logic [4:0]  cnt;
        logic        full;
        logic        empty;
        logic        ovr;
        logic        und;
        logic [13:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [29:0] model_q[$];
    logic [29:0] last_pop = '0;
    logic        m_ovr = 1'b0;
    logic        m_und = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    // Monitor: one expected status per driven cycle, compared just after the edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("items_count", 32'(items_count), 32'(e.cnt));
            chk("full", 32'(full), 32'(e.full));
            chk("empty", 32'(empty), 32'(e.empty));
            chk("overrun", 32'(overrun), 32'(e.ovr));
            chk("underrun", 32'(underrun), 32'(e.und));
            chk("read_address", 32'(read_address), 32'(e.addr));
            chk("read_data", 32'(read_data), 32'(e.data));
            $display("cyc=%0d cnt=%0d full=%0b empty=%0b ovr=%0b und=%0b rd=%04h/%04h",
                     cyc, items_count, full, empty, overrun, underrun, read_address, read_data);
        end
    end

    // Drive one cycle and push what the FIFO should show after that edge.
    task automatic cycle(input logic rst, input logic wr, input logic [13:0] a,
                         input logic [15:0] d, input logic rd);
        exp_t e;
        logic pop_ok, push_ok, ovr_evt, und_evt;
        @(negedge clk);
        reset         = rst;
        write_request = wr;
        write_address = a;
        write_data    = d;
        read_request  = rd;
        if (rst) begin
            model_q.delete();
            last_pop = '0;
            m_ovr = 1'b0;
            m_und = 1'b0;
        end else begin
            pop_ok  = rd && (model_q.size() > 0);
            push_ok = wr && ((model_q.size() < 16) || pop_ok);
            ovr_evt = wr && !push_ok;
            und_evt = rd && (model_q.size() == 0);
            if (pop_ok)  last_pop = model_q.pop_front();
            if (push_ok) model_q.push_back({a, d});
`ifdef VRAM_FIFO_STICKY_ERR_EN
            m_ovr = m_ovr | ovr_evt;
            m_und = m_und | und_evt;
`else
            m_ovr = ovr_evt;
            m_und = und_evt;
`endif
        end
        e.cnt   = 5'(model_q.size());
        e.full  = (model_q.size() == 16);
        e.empty = (model_q.size() == 0);
        e.ovr   = m_ovr;
        e.und   = m_und;
        e.addr  = last_pop[29:16];
        e.data  = last_pop[15:0];
        exp_q.push_back(e);
    endtask

    task automatic idle();     cycle(1'b0, 1'b0, 14'h0, 16'h0, 1'b0); endtask
    task automatic pop();      cycle(1'b0, 1'b0, 14'h0, 16'h0, 1'b1); endtask
    task automatic push(input logic [13:0] a, input logic [15:0] d);
        cycle(1'b0, 1'b1, a, d, 1'b0);
    endtask

    initial begin
        int waited;
        // 1. Reset state
        cycle(1'b1, 1'b0, 14'h0, 16'h0, 1'b0);
        idle();
        // 2. Two pushes, two pops
        push(14'h0010, 16'hAAAA);
        push(14'h0011, 16'h5555);
        pop();
        pop();
        idle();
        // 3. Fill to 16, overrun on the 17th, drain in order
        for (int i = 0; i < 16; i++) push(14'(32'h20 + i), 16'(32'hC000 + i));
        push(14'h3FFF, 16'hDEAD);
        idle();
        for (int i = 0; i < 16; i++) pop();
        idle();
        // 4. Pop while empty
        pop();
        idle();
        pop();
        // 5. Full with push+pop, then empty with push+pop
        for (int i = 0; i < 16; i++) push(14'(32'h80 + i), 16'(32'h1000 * (i % 16) + i));
        cycle(1'b0, 1'b1, 14'h0040, 16'hBEEF, 1'b1);
        idle();
        for (int i = 0; i < 16; i++) pop();
        cycle(1'b0, 1'b1, 14'h0041, 16'h1234, 1'b1);
        idle();
        pop();
        idle();
        // 6. Wrap-around stream with interleaved pops, then reset mid-stream
        for (int i = 0; i < 40; i++)
            cycle(1'b0, 1'b1, 14'(32'h100 + i), 16'(i * 32'h101), (i % 3) != 0);
        for (int i = 0; i < 5; i++) pop();
        cycle(1'b1, 1'b0, 14'h0, 16'h0, 1'b0);
        idle();
        pop();
        push(14'h0200, 16'hF00D);
        pop();
        idle();
        // Let the monitor consume the remaining expectations, bounded.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL monitor_drain pending=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t want=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
